sdp_rdma_dat_rsp: RTL and testbench

Read-side data receiver for the SDP RDMA path and the counterpart of the SDP write-DMA data path. It accepts DMA read responses of two atoms each, steers them against per-request atom counts from the RDMA command generator, and unpacks them into a one-atom-per-beat stream toward the SDP datapath. It also returns one latency-FIFO credit per consumed response and reports layer completion and error status to the register file.

---
 rtl/sdp_rdma_dat_rsp_pkg.sv | 31 +++
 rtl/sdp_rdma_dat_unpack.sv | 73 +++++++
 rtl/sdp_rdma_dat_rsp.sv | 128 ++++++++++++
 tb/tb_sdp_rdma_dat_rsp.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_rdma_dat_rsp_pkg.sv
// Shared SDP RDMA data-response definitions.
// Holds mask encodings, command field offsets, the default atom width and the
// top-level FSM state type used by sdp_rdma_dat_rsp and sdp_rdma_dat_unpack.
package sdp_rdma_dat_rsp_pkg;

  localparam int unsigned AmDwDefault = 256;
  localparam int unsigned CmdDw       = 14;
  localparam int unsigned CntW        = 13;

  // Command payload layout: [12:0] atom count minus one, [13] last command of layer.
  localparam int unsigned CmdCntMsb  = 12;
  localparam int unsigned CmdLastBit = 13;

  typedef enum logic [1:0] {
    MaskNone = 2'b00,
    MaskLo   = 2'b01,
    MaskHi   = 2'b10,
    MaskBoth = 2'b11
  } mask_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Only masks with atom0 present carry data; the others are dropped as errors.
  function automatic logic mask_legal(input mask_e m);
    return (m == MaskLo) || (m == MaskBoth);
  endfunction

endpackage

// File: rtl/sdp_rdma_dat_unpack.sv
// Response holding register and two-atom unpacker.
// Ports:
//   clk, rstn            core clock, synchronous active-low reset
//   enable               response acceptance allowed (running with a live command)
//   one_left             the next atom delivered completes the current command
//   rsp_vld/rsp_rdy/rsp_pd   DMA read response handshake, {mask, atom1, atom0}
//   dp_valid/dp_ready/dp_pd  one-atom-per-beat output stream
//   atom_acc             an atom is accepted downstream this cycle
//   err_set              the retiring response had an illegal mask or a dropped atom1
//   pop                  latency-FIFO credit return, one per retired response
module sdp_rdma_dat_unpack
  import sdp_rdma_dat_rsp_pkg::*;
#(
  parameter int unsigned AM_DW = AmDwDefault
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               one_left,
  input  logic               rsp_vld,
  output logic               rsp_rdy,
  input  logic [2*AM_DW+1:0] rsp_pd,
  output logic               dp_valid,
  input  logic               dp_ready,
  output logic [AM_DW-1:0]   dp_pd,
  output logic               atom_acc,
  output logic               err_set,
  output logic               pop
);

  logic               rsp_vld_q;
  logic               half_q;
  mask_e              mask_q;
  logic [2*AM_DW-1:0] data_q;
  logic               legal;
  logic               rsp_drain;
  logic               rsp_load;

  always_comb begin
    legal    = mask_legal(mask_q);
    dp_valid = rsp_vld_q && legal;
    dp_pd    = half_q ? data_q[2*AM_DW-1:AM_DW] : data_q[AM_DW-1:0];
    atom_acc = dp_valid && dp_ready;
    // Illegal masks retire without emitting; legal ones retire on their final atom,
    // which is atom0 when only one atom is wanted or the command ends here.
    rsp_drain = rsp_vld_q &&
                (!legal || (atom_acc && (half_q || (mask_q != MaskBoth) || one_left)));
    err_set  = rsp_drain && (!legal || ((mask_q == MaskBoth) && !half_q));
    // A response cut short by reset is flushed, not credited.
    pop      = rsp_drain && rstn;
    rsp_rdy  = enable && (!rsp_vld_q || rsp_drain);
    rsp_load = rsp_vld && rsp_rdy;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_vld_q <= 1'b0;
      half_q    <= 1'b0;
      mask_q    <= MaskNone;
      data_q    <= '0;
    end else if (rsp_load) begin
      rsp_vld_q <= 1'b1;
      half_q    <= 1'b0;
      mask_q    <= mask_e'(rsp_pd[2*AM_DW+1:2*AM_DW]);
      data_q    <= rsp_pd[2*AM_DW-1:0];
    end else if (rsp_drain) begin
      rsp_vld_q <= 1'b0;
    end else if (atom_acc) begin
      half_q    <= 1'b1;
    end
  end

endmodule

// File: rtl/sdp_rdma_dat_rsp.sv
// SDP RDMA read-data receiver: matches DMA read responses against per-command
// atom counts and delivers one atom per beat to the SDP datapath.
// Ports:
//   nvdla_core_clk, nvdla_core_rstn      clock, synchronous active-low reset
//   op_load                              layer start pulse (honoured in idle only)
//   cmd2dat_pvld/prdy/pd                 command: {last, atom count minus one}
//   dma_rd_rsp_vld/rdy/pd                read response: {mask, atom1, atom0}
//   dma_rd_cdt_lat_fifo_pop              one credit per retired response
//   sdp_rdma2dp_valid/ready/pd           atom stream to the datapath
//   dp2reg_done                          pulse after the layer's final atom
//   dp2reg_status_err                    sticky mask/count error
//   dp2reg_atom_num                      saturating count of atoms this layer
module sdp_rdma_dat_rsp
  import sdp_rdma_dat_rsp_pkg::*;
#(
  parameter int unsigned AM_DW  = AmDwDefault,
  parameter int unsigned CMD_DW = CmdDw
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  input  logic               op_load,
  input  logic               cmd2dat_pvld,
  output logic               cmd2dat_prdy,
  input  logic [CMD_DW-1:0]  cmd2dat_pd,
  input  logic               dma_rd_rsp_vld,
  output logic               dma_rd_rsp_rdy,
  input  logic [2*AM_DW+1:0] dma_rd_rsp_pd,
  output logic               dma_rd_cdt_lat_fifo_pop,
  output logic               sdp_rdma2dp_valid,
  input  logic               sdp_rdma2dp_ready,
  output logic [AM_DW-1:0]   sdp_rdma2dp_pd,
  output logic               dp2reg_done,
  output logic               dp2reg_status_err,
  output logic [31:0]        dp2reg_atom_num
);

  state_e          state_q, state_d;
  logic            cmd_vld_q;
  logic            last_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] atm_q;
  logic            err_q;
  logic            done_q;
  logic [31:0]     atom_num_q;

  logic run;
  logic one_left;
  logic atom_acc;
  logic err_set;
  logic cmd_finish;
  logic cmd_load;
  logic layer_end;
  logic start;

  always_comb begin
    run        = (state_q == StRun);
    one_left   = cmd_vld_q && (atm_q == cnt_q);
    cmd_finish = atom_acc && one_left;
    // A new command may load in the same cycle the current one finishes.
    cmd2dat_prdy = run && (!cmd_vld_q || cmd_finish);
    cmd_load   = cmd2dat_pvld && cmd2dat_prdy;
    layer_end  = cmd_finish && last_q;
    start      = (state_q == StIdle) && op_load;

    state_d = state_q;
    unique case (state_q)
      StIdle: if (op_load) state_d = StRun;
      StRun:  if (layer_end) state_d = StIdle;
    endcase
  end

  sdp_rdma_dat_unpack #(
    .AM_DW (AM_DW)
  ) u_unpack (
    .clk      (nvdla_core_clk),
    .rstn     (nvdla_core_rstn),
    .enable   (run && cmd_vld_q),
    .one_left (one_left),
    .rsp_vld  (dma_rd_rsp_vld),
    .rsp_rdy  (dma_rd_rsp_rdy),
    .rsp_pd   (dma_rd_rsp_pd),
    .dp_valid (sdp_rdma2dp_valid),
    .dp_ready (sdp_rdma2dp_ready),
    .dp_pd    (sdp_rdma2dp_pd),
    .atom_acc (atom_acc),
    .err_set  (err_set),
    .pop      (dma_rd_cdt_lat_fifo_pop)
  );

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q    <= StIdle;
      cmd_vld_q  <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      atm_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      atom_num_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= layer_end;

      if (cmd_load) begin
        cmd_vld_q <= 1'b1;
        cnt_q     <= cmd2dat_pd[CmdCntMsb:0];
        last_q    <= cmd2dat_pd[CmdLastBit];
        atm_q     <= '0;
      end else begin
        if (cmd_finish) cmd_vld_q <= 1'b0;
        if (atom_acc)   atm_q     <= atm_q + CntW'(1);
      end

      if (start) begin
        err_q      <= 1'b0;
        atom_num_q <= '0;
      end else begin
        if (err_set) err_q <= 1'b1;
        if (atom_acc && (atom_num_q != 32'hFFFF_FFFF)) atom_num_q <= atom_num_q + 32'd1;
      end
    end
  end

  assign dp2reg_done       = done_q;
  assign dp2reg_status_err = err_q;
  assign dp2reg_atom_num   = atom_num_q;

endmodule

// File: tb/tb_sdp_rdma_dat_rsp.sv
// Directed bench for sdp_rdma_dat_rsp: atoms accepted downstream are collected by a
// monitor and compared against hand-computed sequences, counts and status values.
module tb_sdp_rdma_dat_rsp;

  localparam int unsigned AW = 256;

  logic              clk      = 1'b0;
  logic              rstn     = 1'b0;
  logic              op_load  = 1'b0;
  logic              cmd_pvld = 1'b0;
  logic              cmd_prdy;
  logic [13:0]       cmd_pd   = '0;
  logic              rsp_vld  = 1'b0;
  logic              rsp_rdy;
  logic [2*AW+1:0]   rsp_pd   = '0;
  logic              pop;
  logic              dp_valid;
  logic              dp_ready = 1'b1;
  logic [AW-1:0]     dp_pd;
  logic              done;
  logic              err;
  logic [31:0]       atom_num;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int pop_cnt  = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit rdy_toggle = 1'b0;
  logic [AW-1:0] got_q[$];
  int            got_cyc[$];

  sdp_rdma_dat_rsp #(
    .AM_DW  (AW),
    .CMD_DW (14)
  ) dut (
    .nvdla_core_clk          (clk),
    .nvdla_core_rstn         (rstn),
    .op_load                 (op_load),
    .cmd2dat_pvld            (cmd_pvld),
    .cmd2dat_prdy            (cmd_prdy),
    .cmd2dat_pd              (cmd_pd),
    .dma_rd_rsp_vld          (rsp_vld),
    .dma_rd_rsp_rdy          (rsp_rdy),
    .dma_rd_rsp_pd           (rsp_pd),
    .dma_rd_cdt_lat_fifo_pop (pop),
    .sdp_rdma2dp_valid       (dp_valid),
    .sdp_rdma2dp_ready       (dp_ready),
    .sdp_rdma2dp_pd          (dp_pd),
    .dp2reg_done             (done),
    .dp2reg_status_err       (err),
    .dp2reg_atom_num         (atom_num)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    dp_ready = rdy_toggle ? ~dp_ready : 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (rstn && dp_valid && dp_ready) begin
      got_q.push_back(dp_pd);
      got_cyc.push_back(cyc);
    end
    if (pop) pop_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] atom(input int k);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(k);
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer();
    op_load = 1'b1;
    tick();
    op_load = 1'b0;
  endtask

  task automatic send_cmd(input int cnt, input bit last);
    int n = 0;
    cmd_pd   = {last, 13'(cnt)};
    cmd_pvld = 1'b1;
    @(negedge clk);
    while (!cmd_prdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_handshake", AW'(cmd_prdy), AW'(1));
    tick();
    cmd_pvld = 1'b0;
  endtask

  task automatic send_rsp(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [1:0] mask);
    int n = 0;
    rsp_pd  = {mask, a1, a0};
    rsp_vld = 1'b1;
    @(negedge clk);
    while (!rsp_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_handshake", AW'(rsp_rdy), AW'(1));
    tick();
    rsp_vld = 1'b0;
  endtask

  task automatic wait_done(input int db);
    int n = 0;
    while (done_cnt == db && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) tick();
    check("done_once", AW'(done_cnt - db), AW'(1));
  endtask

  task automatic check_atoms(input string tag, input int b, input int first, input int n);
    check({tag, "_count"}, AW'(got_q.size() - b), AW'(n));
    for (int i = 0; i < n; i++) begin
      if (b + i < got_q.size()) check({tag, "_data"}, got_q[b+i], atom(first + i));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, AW'(dp_valid), AW'(0));
    check({tag, "_pd"}, dp_pd, '0);
    check({tag, "_done"}, AW'(done), AW'(0));
    check({tag, "_err"}, AW'(err), AW'(0));
    check({tag, "_atom_num"}, AW'(atom_num), AW'(0));
    check({tag, "_pop"}, AW'(pop), AW'(0));
    check({tag, "_cmd_prdy"}, AW'(cmd_prdy), AW'(0));
    check({tag, "_rsp_rdy"}, AW'(rsp_rdy), AW'(0));
  endtask

  initial begin
    int b;
    int pb;
    int db;
    int last_c;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("reset");
    tick();
    rstn = 1'b1;
    tick();

    // 1: cnt=3 last, two full responses at full rate
    b = got_q.size(); pb = pop_cnt; db = done_cnt;
    start_layer();
    fork
      send_cmd(3, 1'b1);
      begin
        send_rsp(atom(0), atom(1), 2'b11);
        send_rsp(atom(2), atom(3), 2'b11);
      end
    join
    wait_done(db);
    check_atoms("t1", b, 0, 4);
    if (got_q.size() >= b + 4) begin
      for (int i = 1; i < 4; i++) check("t1_gap", AW'(got_cyc[b+i] - got_cyc[b]), AW'(i));
      last_c = got_cyc[b+3];
    end else begin
      last_c = -100;
    end
    check("t1_done_lat", AW'(done_cyc - last_c), AW'(1));
    check("t1_pops", AW'(pop_cnt - pb), AW'(2));
    check("t1_atom_num", AW'(atom_num), AW'(4));
    check("t1_err", AW'(err), AW'(0));

    // 3: cnt=0 with a full response drops atom1 and flags error
    b = got_q.size(); pb = pop_cnt; db = done_cnt;
    start_layer();
    fork
      send_cmd(0, 1'b1);
      send_rsp(atom(20), atom(21), 2'b11);
    join
    wait_done(db);
    check_atoms("t3", b, 20, 1);
    check("t3_pops", AW'(pop_cnt - pb), AW'(1));
    check("t3_atom_num", AW'(atom_num), AW'(1));
    check("t3_err", AW'(err), AW'(1));

    // 2: cnt=2, full then atom0-only response; error cleared by the new layer
    b = got_q.size(); pb = pop_cnt; db = done_cnt;
    start_layer();
    fork
      send_cmd(2, 1'b1);
      begin
        send_rsp(atom(10), atom(11), 2'b11);
        send_rsp(atom(12), atom(13), 2'b01);
      end
    join
    wait_done(db);
    check_atoms("t2", b, 10, 3);
    check("t2_pops", AW'(pop_cnt - pb), AW'(2));
    check("t2_atom_num", AW'(atom_num), AW'(3));
    check("t2_err", AW'(err), AW'(0));

    // 4: mask 2'b10 is dropped with a credit, following response is normal
    b = got_q.size(); pb = pop_cnt; db = done_cnt;
    start_layer();
    fork
      send_cmd(1, 1'b1);
      begin
        send_rsp(atom(30), atom(31), 2'b10);
        send_rsp(atom(32), atom(33), 2'b11);
      end
    join
    wait_done(db);
    check_atoms("t4", b, 32, 2);
    check("t4_pops", AW'(pop_cnt - pb), AW'(2));
    check("t4_atom_num", AW'(atom_num), AW'(2));
    check("t4_err", AW'(err), AW'(1));

    // 5: ready toggling across three cnt=1 commands, no bubbles at handoff
    b = got_q.size(); pb = pop_cnt; db = done_cnt;
    rdy_toggle = 1'b1;
    start_layer();
    fork
      begin
        send_cmd(1, 1'b0);
        send_cmd(1, 1'b0);
        send_cmd(1, 1'b1);
      end
      begin
        send_rsp(atom(40), atom(41), 2'b11);
        send_rsp(atom(42), atom(43), 2'b11);
        send_rsp(atom(44), atom(45), 2'b11);
      end
    join
    wait_done(db);
    rdy_toggle = 1'b0;
    check_atoms("t5", b, 40, 6);
    if (got_q.size() >= b + 6) begin
      for (int i = 1; i < 6; i++) check("t5_gap", AW'(got_cyc[b+i] - got_cyc[b+i-1]), AW'(2));
    end
    check("t5_pops", AW'(pop_cnt - pb), AW'(3));
    check("t5_atom_num", AW'(atom_num), AW'(6));
    check("t5_err", AW'(err), AW'(0));
    repeat (2) tick();

    // 6: reset after the first of four atoms, then a clean restart
    b = got_q.size(); pb = pop_cnt;
    start_layer();
    fork
      send_cmd(3, 1'b1);
      send_rsp(atom(50), atom(51), 2'b11);
    join
    for (int n = 0; n < 50 && got_q.size() == b; n++) @(negedge clk);
    tick();
    rstn = 1'b0;
    tick();
    @(negedge clk);
    check_idle_outputs("t6_flush");
    check_atoms("t6_pre", b, 50, 1);
    check("t6_no_pop", AW'(pop_cnt - pb), AW'(0));
    tick();
    rstn = 1'b1;
    tick();
    b = got_q.size(); pb = pop_cnt; db = done_cnt;
    start_layer();
    @(negedge clk);
    check("t6_restart_atom_num", AW'(atom_num), AW'(0));
    tick();
    fork
      send_cmd(1, 1'b1);
      send_rsp(atom(60), atom(61), 2'b11);
    join
    wait_done(db);
    check_atoms("t6", b, 60, 2);
    check("t6_pops", AW'(pop_cnt - pb), AW'(1));
    check("t6_atom_num", AW'(atom_num), AW'(2));
    check("t6_err", AW'(err), AW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
